// File: rtl/module_control_decodificador.sv
// rtl/module_control_decodificador.sv - sequencing controller for the SECDED Hamming(8,4) decode datapath
module module_control_decodificador #(
  parameter int LATENCIA_DP = 1,
  parameter int ANCHO_CONT  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dato_valido_i,
  output logic                  dato_listo_o,
  input  logic [7:0]            datos_entrada_i,
  output logic [7:0]            datos_dec_o,
  input  logic [2:0]            sindrome_i,
  input  logic                  paridad_global_i,
  input  logic                  error_doble_i,
  input  logic [7:0]            datos_corregidos_i,
  input  logic                  error_simple_i,
  input  logic                  no_error_i,
  output logic                  salida_valida_o,
  input  logic                  salida_acepta_i,
  output logic [3:0]            mensaje_o,
  output logic [7:0]            palabra_o,
  output logic [1:0]            estado_o,
  output logic [ANCHO_CONT-1:0] cont_simple_o,
  output logic [ANCHO_CONT-1:0] cont_doble_o,
  input  logic                  limpiar_cont_i
);

  typedef enum logic [1:0] {
    INACTIVO = 2'b00,
    ESPERA   = 2'b01,
    SALIDA   = 2'b10
  } t_estado;

  localparam logic [1:0] CLASE_NINGUNO = 2'b00;
  localparam logic [1:0] CLASE_SIMPLE  = 2'b01;
  localparam logic [1:0] CLASE_DOBLE   = 2'b10;

  // Settle count loaded on capture; reaching zero in ESPERA is the sampling edge.
  localparam logic [3:0] CARGA_ESPERA = 4'(LATENCIA_DP - 1);
  localparam logic [ANCHO_CONT-1:0] CONT_MAX = {ANCHO_CONT{1'b1}};

  t_estado               r_estado;
  logic [3:0]            r_espera;
  logic [7:0]            r_datos_dec;
  logic [7:0]            r_palabra;
  logic [3:0]            r_mensaje;
  logic [1:0]            r_clase;
  logic                  r_valida;
  logic [ANCHO_CONT-1:0] r_cont_simple;
  logic [ANCHO_CONT-1:0] r_cont_doble;

  logic       w_doble;
  logic       w_simple;
  logic       w_muestra;
  logic [7:0] w_palabra;
  logic [1:0] w_clase;
  logic       w_unused_no_error;

  // A nonzero syndrome with even overall parity cannot come from a single flip.
  assign w_doble   = error_doble_i | ((sindrome_i != 3'b000) & ~paridad_global_i);
  assign w_simple  = error_simple_i | paridad_global_i;
  assign w_clase   = w_doble ? CLASE_DOBLE : (w_simple ? CLASE_SIMPLE : CLASE_NINGUNO);
  // An uncorrectable word is passed on as received rather than miscorrected.
  assign w_palabra = w_doble ? r_datos_dec : datos_corregidos_i;
  assign w_muestra = (r_estado == ESPERA) && (r_espera == 4'd0);

  // The no-error case is simply the absence of both error classes.
  assign w_unused_no_error = no_error_i;

  // Capture / settle / present sequencing with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= INACTIVO;
      r_espera    <= 4'd0;
      r_datos_dec <= 8'd0;
      r_palabra   <= 8'd0;
      r_mensaje   <= 4'd0;
      r_clase     <= CLASE_NINGUNO;
      r_valida    <= 1'b0;
    end else begin
      case (r_estado)
        INACTIVO: begin
          if (dato_valido_i) begin
            r_datos_dec <= datos_entrada_i;
            r_espera    <= CARGA_ESPERA;
            r_estado    <= ESPERA;
          end
        end
        ESPERA: begin
          if (r_espera == 4'd0) begin
            r_palabra <= w_palabra;
            r_mensaje <= {w_palabra[6], w_palabra[5], w_palabra[4], w_palabra[2]};
            r_clase   <= w_clase;
            r_valida  <= 1'b1;
            r_estado  <= SALIDA;
          end else begin
            r_espera <= r_espera - 4'd1;
          end
        end
        SALIDA: begin
          if (salida_acepta_i) begin
            r_valida <= 1'b0;
            r_estado <= INACTIVO;
          end
        end
        default: begin
          r_valida <= 1'b0;
          r_estado <= INACTIVO;
        end
      endcase
    end
  end

  // Saturating error statistics; a clear overrides an increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont_simple <= '0;
      r_cont_doble  <= '0;
    end else if (limpiar_cont_i) begin
      r_cont_simple <= '0;
      r_cont_doble  <= '0;
    end else if (w_muestra) begin
      if (w_clase == CLASE_DOBLE && r_cont_doble != CONT_MAX) begin
        r_cont_doble <= r_cont_doble + 1'b1;
      end
      if (w_clase == CLASE_SIMPLE && r_cont_simple != CONT_MAX) begin
        r_cont_simple <= r_cont_simple + 1'b1;
      end
    end
  end

  assign dato_listo_o    = (r_estado == INACTIVO);
  assign datos_dec_o     = r_datos_dec;
  assign salida_valida_o = r_valida;
  assign mensaje_o       = r_mensaje;
  assign palabra_o       = r_palabra;
  assign estado_o        = r_clase;
  assign cont_simple_o   = r_cont_simple;
  assign cont_doble_o    = r_cont_doble;

endmodule

// File: tb/tb_module_control_decodificador.sv
// tb/tb_module_control_decodificador.sv - self-checking bench for module_control_decodificador
module tb_module_control_decodificador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, valido, acepta, limpiar, sel;
  logic [7:0] entrada;

  // Instance A: LATENCIA_DP=1, ANCHO_CONT=8
  logic       listo_a, val_a, par_a, ed_a, es_a, ne_a;
  logic [7:0] dec_a, pal_a, corr_a, cs_a, cd_a;
  logic [3:0] msg_a;
  logic [1:0] est_a;
  logic [2:0] sind_a;
  // Instance B: LATENCIA_DP=3, ANCHO_CONT=2
  logic       listo_b, val_b, par_b, ed_b, es_b, ne_b;
  logic [7:0] dec_b, pal_b, corr_b;
  logic [1:0] cs_b, cd_b;
  logic [3:0] msg_b;
  logic [1:0] est_b;
  logic [2:0] sind_b;

  int pass = 0;
  int total = 0;
  int exp_cs[2];
  int exp_cd[2];

  // Behavioural detector/corrector standing in for the external datapath
  function automatic logic [2:0] f_sind(input logic [7:0] w);
    return {w[3]^w[4]^w[5]^w[6], w[1]^w[2]^w[5]^w[6], w[0]^w[2]^w[4]^w[6]};
  endfunction

  function automatic logic [7:0] f_corr(input logic [7:0] w);
    logic [7:0] r;
    logic [2:0] s;
    r = w;
    s = f_sind(w);
    if (^w) begin
      if (s == 3'd0) r[7] = ~r[7];
      else r[int'(s) - 1] = ~r[int'(s) - 1];
    end
    return r;
  endfunction

  function automatic logic [7:0] f_enc(input logic [3:0] d);
    logic [7:0] w;
    w = 8'd0;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    w[0] = d[0] ^ d[1] ^ d[3];
    w[1] = d[0] ^ d[2] ^ d[3];
    w[3] = d[1] ^ d[2] ^ d[3];
    w[7] = ^w[6:0];
    return w;
  endfunction

  assign sind_a = f_sind(dec_a);
  assign par_a  = ^dec_a;
  assign corr_a = f_corr(dec_a);
  assign ed_a   = (sind_a != 3'd0) && !par_a;
  assign es_a   = par_a;
  assign ne_a   = (sind_a == 3'd0) && !par_a;

  assign sind_b = f_sind(dec_b);
  assign par_b  = ^dec_b;
  assign corr_b = f_corr(dec_b);
  assign ed_b   = (sind_b != 3'd0) && !par_b;
  assign es_b   = par_b;
  assign ne_b   = (sind_b == 3'd0) && !par_b;

  module_control_decodificador #(.LATENCIA_DP(1), .ANCHO_CONT(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .dato_valido_i(valido & ~sel), .dato_listo_o(listo_a),
    .datos_entrada_i(entrada), .datos_dec_o(dec_a),
    .sindrome_i(sind_a), .paridad_global_i(par_a), .error_doble_i(ed_a),
    .datos_corregidos_i(corr_a), .error_simple_i(es_a), .no_error_i(ne_a),
    .salida_valida_o(val_a), .salida_acepta_i(acepta),
    .mensaje_o(msg_a), .palabra_o(pal_a), .estado_o(est_a),
    .cont_simple_o(cs_a), .cont_doble_o(cd_a), .limpiar_cont_i(limpiar & ~sel)
  );

  module_control_decodificador #(.LATENCIA_DP(3), .ANCHO_CONT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .dato_valido_i(valido & sel), .dato_listo_o(listo_b),
    .datos_entrada_i(entrada), .datos_dec_o(dec_b),
    .sindrome_i(sind_b), .paridad_global_i(par_b), .error_doble_i(ed_b),
    .datos_corregidos_i(corr_b), .error_simple_i(es_b), .no_error_i(ne_b),
    .salida_valida_o(val_b), .salida_acepta_i(acepta),
    .mensaje_o(msg_b), .palabra_o(pal_b), .estado_o(est_b),
    .cont_simple_o(cs_b), .cont_doble_o(cd_b), .limpiar_cont_i(limpiar & sel)
  );

  // View of the instance under test
  logic       listo_v, val_v;
  logic [7:0] dec_v, pal_v, cs_v, cd_v;
  logic [3:0] msg_v;
  logic [1:0] est_v;
  assign listo_v = sel ? listo_b : listo_a;
  assign val_v   = sel ? val_b : val_a;
  assign dec_v   = sel ? dec_b : dec_a;
  assign pal_v   = sel ? pal_b : pal_a;
  assign msg_v   = sel ? msg_b : msg_a;
  assign est_v   = sel ? est_b : est_a;
  assign cs_v    = sel ? {6'd0, cs_b} : cs_a;
  assign cd_v    = sel ? {6'd0, cd_b} : cd_a;

  function automatic int lat_of(input logic s);
    return s ? 3 : 1;
  endfunction

  function automatic int max_of(input logic s);
    return s ? 3 : 255;
  endfunction

  // Send one word; flips = bit errors injected into codeword orig to give w
  task automatic do_word(input logic [7:0] orig, input int flips, input logic [7:0] w, input int hold);
    int lat;
    logic [1:0] e_cls;
    logic [7:0] e_pal;
    logic [3:0] e_msg;
    lat = 0;
    while (!listo_v && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (listo_v !== 1'b1) $display("FAIL listo_wait got=%b exp=1", listo_v); else pass++;
    valido = 1'b1; entrada = w;
    @(posedge clk); #1;
    valido = 1'b0;
    total++; if ({dec_v, listo_v} !== {w, 1'b0}) $display("FAIL capture dec=%h listo=%b exp dec=%h listo=0", dec_v, listo_v, w); else pass++;
    e_cls = (flips == 0) ? 2'b00 : (flips == 1) ? 2'b01 : 2'b10;
    e_pal = (e_cls == 2'b10) ? w : orig;
    e_msg = {e_pal[6], e_pal[5], e_pal[4], e_pal[2]};
    if (e_cls == 2'b01 && exp_cs[sel] < max_of(sel)) exp_cs[sel]++;
    if (e_cls == 2'b10 && exp_cd[sel] < max_of(sel)) exp_cd[sel]++;
    lat = 0;
    while (!val_v && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== lat_of(sel)) $display("FAIL latency got=%0d exp=%0d", lat, lat_of(sel)); else pass++;
    total++; if (pal_v !== e_pal) $display("FAIL palabra got=%h exp=%h", pal_v, e_pal); else pass++;
    total++; if (msg_v !== e_msg) $display("FAIL mensaje got=%h exp=%h", msg_v, e_msg); else pass++;
    total++; if (est_v !== e_cls) $display("FAIL estado got=%b exp=%b", est_v, e_cls); else pass++;
    total++; if (cs_v !== 8'(exp_cs[sel])) $display("FAIL cont_simple got=%0d exp=%0d", cs_v, exp_cs[sel]); else pass++;
    total++; if (cd_v !== 8'(exp_cd[sel])) $display("FAIL cont_doble got=%0d exp=%0d", cd_v, exp_cd[sel]); else pass++;
    acepta = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      total++;
      if ({val_v, pal_v, msg_v, est_v} !== {1'b1, e_pal, e_msg, e_cls})
        $display("FAIL hold_stable got=%b/%h/%h/%b exp=1/%h/%h/%b", val_v, pal_v, msg_v, est_v, e_pal, e_msg, e_cls);
      else pass++;
    end
    acepta = 1'b1;
    @(posedge clk); #1;
    acepta = 1'b0;
    total++; if ({val_v, listo_v} !== 2'b01) $display("FAIL after_accept valid=%b listo=%b exp valid=0 listo=1", val_v, listo_v); else pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valido = 1'b0; acepta = 1'b0; limpiar = 1'b0; sel = 1'b0; entrada = 8'd0;
    exp_cs[0] = 0; exp_cs[1] = 0; exp_cd[0] = 0; exp_cd[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if ({dec_v, pal_v, msg_v, est_v, val_v, cs_v, cd_v, listo_v} !== {8'd0, 8'd0, 4'd0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b1})
        $display("FAIL reset_values inst=%0d dec=%h pal=%h msg=%h est=%b val=%b cs=%0d cd=%0d listo=%b exp all zero listo=1",
                 s, dec_v, pal_v, msg_v, est_v, val_v, cs_v, cd_v, listo_v);
      else pass++;
    end
    sel = 1'b0;
  endtask

  task automatic test_directed;
    sel = 1'b0;
    do_word(8'h66, 0, 8'h66, 0);
    do_word(8'h66, 1, 8'h76, 0);
    do_word(8'h66, 2, 8'h65, 2);
  endtask

  task automatic test_random;
    logic [7:0] o, w;
    int f, b1, b2;
    sel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      o  = f_enc(4'($urandom));
      f  = $urandom_range(0, 2);
      b1 = $urandom_range(0, 7);
      b2 = (b1 + 1 + $urandom_range(0, 6)) % 8;
      w  = o;
      if (f >= 1) w = w ^ (8'd1 << b1);
      if (f == 2) w = w ^ (8'd1 << b2);
      do_word(o, f, w, $urandom_range(0, 3));
    end
  endtask

  task automatic test_hold;
    logic [7:0] w2;
    int lat;
    sel = 1'b1;
    w2 = f_enc(4'hA);
    valido = 1'b1; entrada = 8'h66;
    @(posedge clk); #1;
    entrada = w2;
    total++; if (dec_v !== 8'h66) $display("FAIL hold_capture got=%h exp=66", dec_v); else pass++;
    lat = 0;
    while (!val_v && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 3) $display("FAIL hold_latency got=%0d exp=3", lat); else pass++;
    repeat (5) begin
      @(posedge clk); #1;
      total++;
      if ({val_v, pal_v, msg_v, est_v, dec_v, listo_v} !== {1'b1, 8'h66, 4'hD, 2'b00, 8'h66, 1'b0})
        $display("FAIL hold_stable_b got=%b/%h/%h/%b/%h/%b exp=1/66/d/00/66/0", val_v, pal_v, msg_v, est_v, dec_v, listo_v);
      else pass++;
    end
    acepta = 1'b1;
    @(posedge clk); #1;
    acepta = 1'b0;
    total++; if ({val_v, listo_v, dec_v} !== {1'b0, 1'b1, 8'h66}) $display("FAIL hold_release got=%b/%b/%h exp=0/1/66", val_v, listo_v, dec_v); else pass++;
    @(posedge clk); #1;
    valido = 1'b0;
    total++; if ({listo_v, dec_v} !== {1'b0, w2}) $display("FAIL hold_next_capture got=%b/%h exp=0/%h", listo_v, dec_v, w2); else pass++;
    lat = 0;
    while (!val_v && lat < 40) begin @(posedge clk); #1; lat++; end
    acepta = 1'b1;
    @(posedge clk); #1;
    acepta = 1'b0;
  endtask

  task automatic test_saturation;
    logic [7:0] o, w;
    int b1, b2, lat;
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      o = f_enc(4'($urandom));
      w = o ^ (8'd1 << $urandom_range(0, 7));
      do_word(o, 1, w, 0);
    end
    total++; if (cs_v !== 8'd3) $display("FAIL saturate got=%0d exp=3", cs_v); else pass++;
    o  = f_enc(4'($urandom));
    b1 = $urandom_range(0, 7);
    b2 = (b1 + 1 + $urandom_range(0, 6)) % 8;
    w  = o ^ (8'd1 << b1) ^ (8'd1 << b2);
    valido = 1'b1; entrada = w;
    @(posedge clk); #1;
    valido = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    limpiar = 1'b1;
    @(posedge clk); #1;
    limpiar = 1'b0;
    exp_cs[1] = 0; exp_cd[1] = 0;
    total++;
    if ({val_v, est_v, cs_v, cd_v} !== {1'b1, 2'b10, 8'd0, 8'd0})
      $display("FAIL clear_wins got val=%b est=%b cs=%0d cd=%0d exp val=1 est=10 cs=0 cd=0", val_v, est_v, cs_v, cd_v);
    else pass++;
    acepta = 1'b1;
    @(posedge clk); #1;
    acepta = 1'b0;
    lat = 0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] o;
    sel = 1'b1;
    o = f_enc(4'h3);
    do_word(o, 1, o ^ 8'h10, 0);
    valido = 1'b1; entrada = o ^ 8'h01;
    @(posedge clk); #1;
    valido = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if ({val_v, dec_v, listo_v, cs_v} !== {1'b0, 8'd0, 1'b1, 8'd0}) $display("FAIL reset_async got=%b/%h/%b/%0d exp=0/00/1/0", val_v, dec_v, listo_v, cs_v); else pass++;
    exp_cs[0] = 0; exp_cs[1] = 0; exp_cd[0] = 0; exp_cd[1] = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      total++; if ({val_v, listo_v} !== 2'b01) $display("FAIL reset_mid_idle got valid=%b listo=%b exp 0/1", val_v, listo_v); else pass++;
    end
    total++;
    if ({pal_v, msg_v, est_v, cs_v, cd_v} !== {8'd0, 4'd0, 2'b00, 8'd0, 8'd0})
      $display("FAIL reset_mid_outputs got=%h/%h/%b/%0d/%0d exp zeros", pal_v, msg_v, est_v, cs_v, cd_v);
    else pass++;
    sel = 1'b0;
    #1;
    total++; if ({cs_v, cd_v, dec_v} !== {8'd0, 8'd0, 8'd0}) $display("FAIL reset_mid_inst_a got=%0d/%0d/%h exp 0/0/00", cs_v, cd_v, dec_v); else pass++;
  endtask

  task automatic test_back_to_back;
    int nv, nl;
    sel = 1'b0;
    nv = 0; nl = 0;
    acepta = 1'b1; valido = 1'b1; entrada = 8'h66;
    repeat (30) begin
      @(posedge clk); #1;
      if (val_v) nv++;
      if (listo_v) nl++;
    end
    valido = 1'b0;
    @(posedge clk); #1;
    acepta = 1'b0;
    total++; if (nv !== 10) $display("FAIL b2b_valid_cycles got=%0d exp=10", nv); else pass++;
    total++; if (nl !== 10) $display("FAIL b2b_ready_cycles got=%0d exp=10", nl); else pass++;
    total++; if ({cs_v, cd_v} !== {8'd0, 8'd0}) $display("FAIL b2b_counters got=%0d/%0d exp 0/0", cs_v, cd_v); else pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass, total);
    $fatal(1, "timeout");
  end

endmodule
